// File: rtl/reservation_station.sv
// Unified reservation station: allocates one decoded instruction per cycle,
// resolves operands from regfile/ROB/CDB, and issues one ready entry per cycle.
package rs_pkg;
    localparam int RS_LEN = 8;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 5;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
        logic [REG_W-1:0] dest_reg_idx;
    } id_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs1_ready;
        logic             rs2_ready;
    } mt2rs_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] reg_tag;
        logic [XLEN-1:0]  reg_value;
    } cdb_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] rob_entry;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
    } rob2rs_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
    } rs2rob_packet_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest_reg_idx;
        logic [TAG_W-1:0] dest_reg_tag;
    } rs2mt_packet_t;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
        logic [REG_W-1:0] dest_reg_idx;
        logic [TAG_W-1:0] rob_tag;
    } is_packet_t;
endpackage

module reservation_station
    import rs_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  id_packet_t            id_packet_in,
    input  mt2rs_packet_t         mt2rs_packet_in,
    input  cdb_packet_t           cdb_packet_in,
    input  rob2rs_packet_t        rob2rs_packet_in,
    input  logic [RS_LEN-1:0]     rs_entry_clear_in,
    output rs2rob_packet_t        rs2rob_packet_out,
    output rs2mt_packet_t         rs2mt_packet_out,
    output is_packet_t            is_packet_out,
    output logic [RS_LEN-1:0]     rs_entry_clear_out
);
    localparam int IDX_W = $clog2(RS_LEN);

    logic [RS_LEN-1:0] busy_q, busy_d, issued_q, issued_d;
    logic [RS_LEN-1:0] rs1_valid_q, rs1_valid_d, rs2_valid_q, rs2_valid_d;
    logic [XLEN-1:0]   entry_inst_q [RS_LEN];
    logic [XLEN-1:0]   entry_inst_d [RS_LEN];
    logic [XLEN-1:0]   rs1_val_q [RS_LEN];
    logic [XLEN-1:0]   rs1_val_d [RS_LEN];
    logic [XLEN-1:0]   rs2_val_q [RS_LEN];
    logic [XLEN-1:0]   rs2_val_d [RS_LEN];
    logic [TAG_W-1:0]  rs1_tag_q [RS_LEN];
    logic [TAG_W-1:0]  rs1_tag_d [RS_LEN];
    logic [TAG_W-1:0]  rs2_tag_q [RS_LEN];
    logic [TAG_W-1:0]  rs2_tag_d [RS_LEN];
    logic [TAG_W-1:0]  rob_tag_q [RS_LEN];
    logic [TAG_W-1:0]  rob_tag_d [RS_LEN];
    logic [REG_W-1:0]  dest_q [RS_LEN];
    logic [REG_W-1:0]  dest_d [RS_LEN];

    logic [RS_LEN-1:0] rs_entry_busy, rs_entry_ready, rs_entry_enable, issue_sel;
    logic [IDX_W-1:0]  issue_idx;
    logic              alloc, found_free, found_ready;
    logic [XLEN-1:0]   new_rs1_val, new_rs2_val;
    logic              new_rs1_valid, new_rs2_valid;

    assign rs_entry_busy = busy_q;
    assign rs_entry_ready = busy_q & rs1_valid_q & rs2_valid_q & ~issued_q;
    assign alloc = id_packet_in.valid && (rs_entry_enable != '0);

    always_comb begin
        rs_entry_enable = '0;
        found_free      = 1'b0;
        issue_sel       = '0;
        issue_idx       = '0;
        found_ready     = 1'b0;
        for (int i = 0; i < RS_LEN; i++) begin
            if (!busy_q[i] && !found_free) begin
                rs_entry_enable[i] = 1'b1;
                found_free         = 1'b1;
            end
            if (rs_entry_ready[i] && !found_ready) begin
                issue_sel[i] = 1'b1;
                issue_idx    = IDX_W'(i);
                found_ready  = 1'b1;
            end
        end
    end

    // Operand source priority at allocation: regfile, ROB, then a same-cycle CDB hit.
    always_comb begin
        new_rs1_val   = mt2rs_packet_in.rs1_tag;
        new_rs1_valid = 1'b0;
        if (mt2rs_packet_in.rs1_tag == '0) begin
            new_rs1_val = id_packet_in.rs1_value; new_rs1_valid = 1'b1;
        end else if (mt2rs_packet_in.rs1_ready) begin
            new_rs1_val = rob2rs_packet_in.rs1_value; new_rs1_valid = 1'b1;
        end else if (cdb_packet_in.reg_tag == mt2rs_packet_in.rs1_tag) begin
            new_rs1_val = cdb_packet_in.reg_value; new_rs1_valid = 1'b1;
        end
        new_rs2_val   = mt2rs_packet_in.rs2_tag;
        new_rs2_valid = 1'b0;
        if (mt2rs_packet_in.rs2_tag == '0) begin
            new_rs2_val = id_packet_in.rs2_value; new_rs2_valid = 1'b1;
        end else if (mt2rs_packet_in.rs2_ready) begin
            new_rs2_val = rob2rs_packet_in.rs2_value; new_rs2_valid = 1'b1;
        end else if (cdb_packet_in.reg_tag == mt2rs_packet_in.rs2_tag) begin
            new_rs2_val = cdb_packet_in.reg_value; new_rs2_valid = 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q; issued_d = issued_q;
        rs1_valid_d = rs1_valid_q; rs2_valid_d = rs2_valid_q;
        entry_inst_d = entry_inst_q; rs1_val_d = rs1_val_q; rs2_val_d = rs2_val_q;
        rs1_tag_d = rs1_tag_q; rs2_tag_d = rs2_tag_q; rob_tag_d = rob_tag_q; dest_d = dest_q;
        for (int i = 0; i < RS_LEN; i++) begin
            if (busy_q[i] && cdb_packet_in.reg_tag != '0) begin
                if (!rs1_valid_q[i] && rs1_tag_q[i] == cdb_packet_in.reg_tag) begin
                    rs1_val_d[i] = cdb_packet_in.reg_value; rs1_valid_d[i] = 1'b1;
                end
                if (!rs2_valid_q[i] && rs2_tag_q[i] == cdb_packet_in.reg_tag) begin
                    rs2_val_d[i] = cdb_packet_in.reg_value; rs2_valid_d[i] = 1'b1;
                end
            end
            if (issue_sel[i]) issued_d[i] = 1'b1;
            // Clear overrides a same-cycle issue of the same entry.
            if (rs_entry_clear_in[i]) begin
                busy_d[i] = 1'b0; issued_d[i] = 1'b0;
            end
            if (alloc && rs_entry_enable[i]) begin
                busy_d[i] = 1'b1; issued_d[i] = 1'b0;
                entry_inst_d[i] = id_packet_in.inst;
                dest_d[i] = id_packet_in.dest_reg_idx;
                rob_tag_d[i] = rob2rs_packet_in.rob_entry;
                rs1_tag_d[i] = mt2rs_packet_in.rs1_tag; rs2_tag_d[i] = mt2rs_packet_in.rs2_tag;
                rs1_val_d[i] = new_rs1_val; rs1_valid_d[i] = new_rs1_valid;
                rs2_val_d[i] = new_rs2_val; rs2_valid_d[i] = new_rs2_valid;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0; issued_q <= '0; rs1_valid_q <= '0; rs2_valid_q <= '0;
            for (int i = 0; i < RS_LEN; i++) begin
                entry_inst_q[i] <= '0; rs1_val_q[i] <= '0; rs2_val_q[i] <= '0;
                rs1_tag_q[i] <= '0; rs2_tag_q[i] <= '0; rob_tag_q[i] <= '0; dest_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d; issued_q <= issued_d;
            rs1_valid_q <= rs1_valid_d; rs2_valid_q <= rs2_valid_d;
            entry_inst_q <= entry_inst_d; rs1_val_q <= rs1_val_d; rs2_val_q <= rs2_val_d;
            rs1_tag_q <= rs1_tag_d; rs2_tag_q <= rs2_tag_d; rob_tag_q <= rob_tag_d; dest_q <= dest_d;
        end
    end

    always_comb begin
        rs2rob_packet_out  = '0;
        rs2mt_packet_out   = '0;
        is_packet_out      = '0;
        rs_entry_clear_out = '0;
        if (!reset) begin
            rs2rob_packet_out.rs1_tag      = mt2rs_packet_in.rs1_tag;
            rs2rob_packet_out.rs2_tag      = mt2rs_packet_in.rs2_tag;
            rs2mt_packet_out.valid         = alloc;
            rs2mt_packet_out.dest_reg_idx  = id_packet_in.dest_reg_idx;
            rs2mt_packet_out.dest_reg_tag  = rob2rs_packet_in.rob_entry;
            if (found_ready) begin
                is_packet_out.valid        = 1'b1;
                is_packet_out.inst         = entry_inst_q[issue_idx];
                is_packet_out.rs1_value    = rs1_val_q[issue_idx];
                is_packet_out.rs2_value    = rs2_val_q[issue_idx];
                is_packet_out.dest_reg_idx = dest_q[issue_idx];
                is_packet_out.rob_tag      = rob_tag_q[issue_idx];
                rs_entry_clear_out         = issue_sel;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: table of allocation-time operand
// resolution cases plus hand-written multi-cycle sequences.
module tb_reservation_station;
    import rs_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    id_packet_t        id_packet_in;
    mt2rs_packet_t     mt2rs_packet_in;
    cdb_packet_t       cdb_packet_in;
    rob2rs_packet_t    rob2rs_packet_in;
    logic [RS_LEN-1:0] rs_entry_clear_in;
    rs2rob_packet_t    rs2rob_packet_out;
    rs2mt_packet_t     rs2mt_packet_out;
    is_packet_t        is_packet_out;
    logic [RS_LEN-1:0] rs_entry_clear_out;

    int checks = 0;
    int failures = 0;

    reservation_station dut (
        .clock(clock), .reset(reset),
        .id_packet_in(id_packet_in), .mt2rs_packet_in(mt2rs_packet_in),
        .cdb_packet_in(cdb_packet_in), .rob2rs_packet_in(rob2rs_packet_in),
        .rs_entry_clear_in(rs_entry_clear_in),
        .rs2rob_packet_out(rs2rob_packet_out), .rs2mt_packet_out(rs2mt_packet_out),
        .is_packet_out(is_packet_out), .rs_entry_clear_out(rs_entry_clear_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  t1, t2;
        logic        r1, r2;
        logic [31:0] iv1, iv2, rv1, rv2;
        logic [4:0]  cdb_tag;
        logic [31:0] cdb_val;
        logic        exp_ready;
        logic [31:0] exp_v1, exp_v2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_alloc(input logic [31:0] inst, input logic [4:0] t1, input logic [4:0] t2,
                               input logic r1, input logic r2,
                               input logic [31:0] iv1, input logic [31:0] iv2,
                               input logic [31:0] rv1, input logic [31:0] rv2,
                               input logic [4:0] rob, input logic [4:0] dest);
        id_packet_in.valid = 1'b1;
        id_packet_in.inst = inst;
        id_packet_in.rs1_value = iv1;
        id_packet_in.rs2_value = iv2;
        id_packet_in.dest_reg_idx = dest;
        mt2rs_packet_in.rs1_tag = t1;
        mt2rs_packet_in.rs2_tag = t2;
        mt2rs_packet_in.rs1_ready = r1;
        mt2rs_packet_in.rs2_ready = r2;
        rob2rs_packet_in.rob_entry = rob;
        rob2rs_packet_in.rs1_value = rv1;
        rob2rs_packet_in.rs2_value = rv2;
    endtask

    task automatic set_cdb(input logic [4:0] tag, input logic [31:0] val);
        cdb_packet_in.reg_tag = tag;
        cdb_packet_in.reg_value = val;
    endtask

    initial begin
        vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 5'd0, 32'h0, 1'b1, 32'h11, 32'h22};
        vecs[1] = '{5'd2, 5'd0, 1'b1, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 5'd0, 32'h0, 1'b1, 32'h33, 32'h22};
        vecs[2] = '{5'd3, 5'd0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 5'd3, 32'h77, 1'b1, 32'h77, 32'h22};
        vecs[3] = '{5'd3, 5'd0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 5'd5, 32'h77, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{5'd0, 5'd6, 1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 5'd0, 32'h0, 1'b1, 32'h11, 32'h44};
        vecs[5] = '{5'd7, 5'd8, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 5'd8, 32'h99, 1'b0, 32'h0, 32'h0};

        reset = 1'b1;
        id_packet_in = '0; mt2rs_packet_in = '0; cdb_packet_in = '0; rob2rs_packet_in = '0;
        rs_entry_clear_in = '0;
        step(); step();
        check("reset_busy", 64'(dut.rs_entry_busy), 64'h0);
        check("reset_is_valid", 64'(is_packet_out.valid), 64'h0);
        check("reset_clear_out", 64'(rs_entry_clear_out), 64'h0);
        reset = 1'b0;

        // Test 1: all operands from regfile.
        drive_alloc(32'hABCDEF12, 5'd0, 5'd0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 5'd1, 5'd3);
        #1;
        check("t1_enable", 64'(dut.rs_entry_enable), 64'h1);
        check("t1_rs2mt_valid", 64'(rs2mt_packet_out.valid), 64'h1);
        check("t1_rs2mt_tag", 64'(rs2mt_packet_out.dest_reg_tag), 64'h1);
        step();
        id_packet_in.valid = 1'b0;
        #1;
        check("t1_busy0", 64'(dut.rs_entry_busy[0]), 64'h1);
        check("t1_ready0", 64'(dut.rs_entry_ready[0]), 64'h1);
        check("t1_is_inst", 64'(is_packet_out.inst), 64'hABCDEF12);
        check("t1_clear_out", 64'(rs_entry_clear_out), 64'h1);
        step();
        check("t1_no_reissue", 64'(is_packet_out.valid), 64'h0);

        // Test 2: operands ready in ROB.
        drive_alloc(32'h2222, 5'd1, 5'd1, 1'b1, 1'b1, 32'h0, 32'h0, 32'd5, 32'd6, 5'd2, 5'd4);
        step();
        id_packet_in.valid = 1'b0;
        #1;
        check("t2_ready1", 64'(dut.rs_entry_ready[1]), 64'h1);
        check("t2_ops", {is_packet_out.rs1_value, is_packet_out.rs2_value}, {32'd5, 32'd6});
        check("t2_rob_tag", 64'(is_packet_out.rob_tag), 64'h2);
        step();

        // Test 3: both operands wait on one CDB tag.
        drive_alloc(32'h3333, 5'd1, 5'd1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd5);
        step();
        id_packet_in.valid = 1'b0;
        #1;
        check("t3_not_ready", 64'(dut.rs_entry_ready[2]), 64'h0);
        check("t3_no_issue", 64'(is_packet_out.valid), 64'h0);
        set_cdb(5'd1, 32'd1);
        step();
        set_cdb(5'd0, 32'd0);
        #1;
        check("t3_ready", 64'(dut.rs_entry_ready[2]), 64'h1);
        check("t3_ops", {is_packet_out.rs1_value, is_packet_out.rs2_value}, {32'd1, 32'd1});
        check("t3_clear_out", 64'(rs_entry_clear_out), 64'h4);
        step();
        rs_entry_clear_in = 8'b0000_0111;
        step();
        rs_entry_clear_in = '0;
        check("t3_freed", 64'(dut.rs_entry_busy), 64'h0);

        // Test 4: two different tags woken in successive cycles.
        drive_alloc(32'h4444, 5'd3, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6);
        step();
        id_packet_in.valid = 1'b0;
        set_cdb(5'd4, 32'd10);
        step();
        check("t4_half_ready", 64'(dut.rs_entry_ready[0]), 64'h0);
        set_cdb(5'd3, 32'd10);
        step();
        set_cdb(5'd0, 32'd0);
        #1;
        check("t4_ready", 64'(dut.rs_entry_ready[0]), 64'h1);
        check("t4_ops", {is_packet_out.rs1_value, is_packet_out.rs2_value}, {32'd10, 32'd10});
        rs_entry_clear_in = 8'h01;
        step();
        rs_entry_clear_in = '0;

        // Operand resolution table, always into entry 0.
        for (int v = 0; v < 6; v++) begin
            drive_alloc(32'h5000 + 32'(v), vecs[v].t1, vecs[v].t2, vecs[v].r1, vecs[v].r2,
                        vecs[v].iv1, vecs[v].iv2, vecs[v].rv1, vecs[v].rv2, 5'd9, 5'd1);
            set_cdb(vecs[v].cdb_tag, vecs[v].cdb_val);
            step();
            id_packet_in.valid = 1'b0;
            set_cdb(5'd0, 32'd0);
            #1;
            check($sformatf("vec%0d_ready", v), 64'(dut.rs_entry_ready[0]), 64'(vecs[v].exp_ready));
            if (vecs[v].exp_ready)
                check($sformatf("vec%0d_ops", v), {is_packet_out.rs1_value, is_packet_out.rs2_value},
                      {vecs[v].exp_v1, vecs[v].exp_v2});
            // Clear lands on the same cycle the entry would issue.
            rs_entry_clear_in = 8'h01;
            step();
            rs_entry_clear_in = '0;
            check($sformatf("vec%0d_freed", v), 64'(dut.rs_entry_busy), 64'h0);
            check($sformatf("vec%0d_idle", v), 64'(is_packet_out.valid), 64'h0);
        end

        // Test 5: fill, overflow attempt, then reuse a freed slot.
        for (int k = 0; k < RS_LEN; k++) begin
            drive_alloc(32'h100 + 32'(k), 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'(k), 5'(k));
            step();
        end
        drive_alloc(32'h999, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd20, 5'd20);
        #1;
        check("t5_busy_full", 64'(dut.rs_entry_busy), 64'hFF);
        check("t5_enable_zero", 64'(dut.rs_entry_enable), 64'h0);
        check("t5_rs2mt_invalid", 64'(rs2mt_packet_out.valid), 64'h0);
        step();
        for (int k = 0; k < RS_LEN; k++)
            check($sformatf("t5_keep%0d", k), 64'(dut.entry_inst_q[k]), 64'h100 + 64'(k));
        rs_entry_clear_in = 8'b0010_0000;
        #1;
        check("t5_no_same_cycle", 64'(rs2mt_packet_out.valid), 64'h0);
        step();
        rs_entry_clear_in = '0;
        #1;
        check("t5_enable5", 64'(dut.rs_entry_enable), 64'h20);
        check("t5_rs2mt_valid", 64'(rs2mt_packet_out.valid), 64'h1);
        step();
        id_packet_in.valid = 1'b0;
        #1;
        check("t5_slot5", 64'(dut.entry_inst_q[5]), 64'h999);
        check("t5_issue5", {32'(rs_entry_clear_out), is_packet_out.inst}, {32'h20, 32'h999});

        // Test 6: asynchronous reset between edges.
        drive_alloc(32'h6666, 5'd9, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy", 64'(dut.rs_entry_busy), 64'h0);
        check("t6_is_valid", 64'(is_packet_out.valid), 64'h0);
        check("t6_clear_out", 64'(rs_entry_clear_out), 64'h0);
        check("t6_rs2mt_valid", 64'(rs2mt_packet_out.valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
